alu_ctrl_muldiv: RTL and testbench
==================================

# alu_ctrl_muldiv

Second-generation ALU control block for the MIPS core. It extends the combinational funct/aluop decoder to a 4-bit ALU control space covering xor, nor, sltu and the shifts. It also owns the HI/LO register pair and an iterative multiply/divide sequencer, with a stall handshake. It sits between the main decoder and the datapath: alucontrol drives the ALU, and hilo_rd/muldiv_sel feed the result mux.

## Interface
Parameters:
- WIDTH, 32, datapath width; sets operand width and the iteration count.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  rising-edge clock.
  - reset  in  1  synchronous reset.
- valid  in  1  instruction in decode is live this cycle.
- aluop  in  2  from main decoder.
- funct  in  6  instr[5:0].
- srca, srcb  in  WIDTH  register operands (rs, rt).
- alucontrol  out  4  ALU operation.
- illegal  out  1  aluop=10 with unrecognised funct.
- muldiv_sel  out  1  result mux selects hilo_rd (mfhi/mflo).
- hilo_rd  out  WIDTH  HI for mfhi, else LO.
- busy  out  1  sequencer not IDLE.
- stall  out  1  hold decode this cycle.
- divzero  out  1  one-cycle pulse, divide by zero completed.

## Operation
Decode is combinational.
- aluop 00 → 0010 (add); 01 → 0110 (sub); 11 → 0111 (slt, slti).
- aluop 10, by funct:
  - add/addu 10000x → 0010; sub/subu 10001x → 0110.
  - and 100100 → 0000; or 100101 → 0001; xor 100110 → 0011; nor 100111 → 0100.
  - slt 101010 → 0111; sltu 101011 → 1111.
  - sll 000000 → 1000; srl 000010 → 1001; sra 000011 → 1010.
- HI/LO-class funct drives alucontrol 0010 with illegal=0:
  - mult 011000, multu 011001, div 011010, divu 011011.
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- Any other funct: alucontrol 0010, illegal=1.
- muldiv_sel=1 for mfhi/mflo when aluop=10.

Sequencer FSM:
- States: IDLE, RUN, FIX.
- IDLE → RUN when valid and mult/div class. Latch op, signedness, |srca|, |srcb| and operand signs; count←0.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle; count++. After WIDTH steps → FIX.
- FIX: apply sign correction, write HI/LO, → IDLE.
- Signed sign correction:
  - Product negated if operand signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero (srcb=0, signed or unsigned): HI←srca, LO←all ones, divzero pulses.
- Most-negative ÷ −1: LO=most-negative, HI=0.
- mthi/mtlo in IDLE with valid: HI/LO←srca at the edge.

Stall rules:
- stall = valid & busy & HI/LO-class funct & aluop=10.
- A stalled instruction has no side effect and is re-presented until stall=0.
- Non-HI/LO instructions never stall.

## Timing
- Accept edge E0. busy is high from E0 until edge E(WIDTH+1), i.e. WIDTH+1 cycles.
- HI/LO take the new value at E(WIDTH+1). divzero is high for the cycle following E(WIDTH+1).
- mfhi issued in the FIX cycle stalls; the next cycle it reads the new value.
- New mult/div can be accepted the cycle busy falls (back-to-back).
- Reset values: busy=0, HI=LO=0 (so hilo_rd=0), divzero=0, state IDLE, count=0.
- Reset mid-operation aborts: the next cycle busy=0 and HI=LO=0.
- alucontrol, illegal, muldiv_sel and stall are combinational, with no reset state.

## Structure
- Package alu_pkg holds:
  - ALUCTL_* 4-bit localparams.
  - FUNCT_* 6-bit localparams.
  - The sequencer state enum.
- Sub-module muldiv_iter (parameter WIDTH) holds the FSM, counter, iteration datapath and HI/LO.
- The top level is the decoder plus stall logic.

## Test plan
All scenarios use WIDTH=32.
- Decode sweep: each listed funct with aluop=10, plus aluop 00/01/11 → codes above; funct 111111 → illegal=1, alucontrol=0010.
- mult srca=7, srcb=0xFFFFFFFD → busy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB; multu on the same operands → HI=0x00000006, LO=0xFFFFFFEB.
- divu 100/7 → LO=14, HI=2; div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div srca=5, srcb=0 → HI=5, LO=0xFFFFFFFF, divzero high exactly one cycle.
- mflo presented 5 cycles after a mult accept → stall high until busy falls; then hilo_rd=the new LO and muldiv_sel=1. An add presented while busy → stall=0.
- reset asserted in cycle 10 of a mult → the next cycle busy=0, HI=LO=0, and no divzero pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, funct encodings and multiply/divide sequencer state
package alu_pkg;
  localparam logic [3:0] ALUCTL_AND  = 4'b0000;
  localparam logic [3:0] ALUCTL_OR   = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD  = 4'b0010;
  localparam logic [3:0] ALUCTL_XOR  = 4'b0011;
  localparam logic [3:0] ALUCTL_NOR  = 4'b0100;
  localparam logic [3:0] ALUCTL_SUB  = 4'b0110;
  localparam logic [3:0] ALUCTL_SLT  = 4'b0111;
  localparam logic [3:0] ALUCTL_SLL  = 4'b1000;
  localparam logic [3:0] ALUCTL_SRL  = 4'b1001;
  localparam logic [3:0] ALUCTL_SRA  = 4'b1010;
  localparam logic [3:0] ALUCTL_SLTU = 4'b1111;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} md_state_e;
endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// alu_ctrl_muldiv_if: decode-side request and result bundle for the ALU control block
interface alu_ctrl_muldiv_if #(parameter int WIDTH = 32);
  logic             valid;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [3:0]       alucontrol;
  logic             illegal;
  logic             muldiv_sel;
  logic [WIDTH-1:0] hilo_rd;
  logic             busy;
  logic             stall;
  logic             divzero;
  modport master (
    output valid, aluop, funct, srca, srcb,
    input  alucontrol, illegal, muldiv_sel, hilo_rd, busy, stall, divzero
  );
  modport slave (
    input  valid, aluop, funct, srca, srcb,
    output alucontrol, illegal, muldiv_sel, hilo_rd, busy, stall, divzero
  );
endinterface

// File: rtl/alu_ctrl_muldiv_muldiv_iter.sv
// muldiv_iter: iterative shift-add multiply / restoring divide sequencer owning HI/LO
module muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             divzero
);
  localparam int CW = $clog2(WIDTH) + 1;
  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, dzp_q, dzp_d;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b, rnew, quo, rem;
  logic [WIDTH:0]     sum, shl, diff;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    sa      = op_signed & srca[WIDTH-1];
    sb      = op_signed & srcb[WIDTH-1];
    mag_a   = sa ? -srca : srca;
    mag_b   = sb ? -srcb : srcb;
    sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    shl     = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    diff    = shl - {1'b0, b_q};
    rnew    = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
    prod    = neg_q ? -p_q : p_q;
    quo     = dz_q ? '1 : (neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0]);
    rem     = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    dzp_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          div_d   = op_div;
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          dz_d    = op_div & (srcb == '0);
          p_d     = {{WIDTH{1'b0}}, mag_a};
          b_d     = mag_b;
        end
        hi_d = mthi_we ? srca : hi_q;
        lo_d = mtlo_we ? srca : lo_q;
      end
      ST_RUN: begin
        cnt_d   = cnt_q + 1'b1;
        p_d     = div_q ? {rnew, p_q[WIDTH-2:0], ~diff[WIDTH]} : {sum, p_q[WIDTH-1:1]};
        state_d = (cnt_q == CW'(WIDTH - 1)) ? ST_FIX : ST_RUN;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d    = div_q ? quo : prod[WIDTH-1:0];
        dzp_d   = div_q & dz_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      dzp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      dzp_q   <= dzp_d;
    end
  end
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = state_q != ST_IDLE;
  assign divzero = dzp_q;
endmodule

// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv: funct/aluop decoder with HI/LO stall logic around the mul/div sequencer
module alu_ctrl_muldiv import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  alu_ctrl_muldiv_if.slave bus
);
  logic             rtype, md_cls, hilo_cls, start, mthi_we, mtlo_we;
  logic [WIDTH-1:0] hi, lo;
  always_comb begin
    rtype          = bus.aluop == 2'b10;
    md_cls         = bus.funct[5:2] == 4'b0110;
    hilo_cls       = md_cls | (bus.funct[5:2] == 4'b0100);
    bus.illegal    = 1'b0;
    bus.alucontrol = ALUCTL_ADD;
    case (bus.aluop)
      2'b01: bus.alucontrol = ALUCTL_SUB;
      2'b11: bus.alucontrol = ALUCTL_SLT;
      2'b10: begin
        case (bus.funct)
          FUNCT_ADD, FUNCT_ADDU: bus.alucontrol = ALUCTL_ADD;
          FUNCT_SUB, FUNCT_SUBU: bus.alucontrol = ALUCTL_SUB;
          FUNCT_AND:  bus.alucontrol = ALUCTL_AND;
          FUNCT_OR:   bus.alucontrol = ALUCTL_OR;
          FUNCT_XOR:  bus.alucontrol = ALUCTL_XOR;
          FUNCT_NOR:  bus.alucontrol = ALUCTL_NOR;
          FUNCT_SLT:  bus.alucontrol = ALUCTL_SLT;
          FUNCT_SLTU: bus.alucontrol = ALUCTL_SLTU;
          FUNCT_SLL:  bus.alucontrol = ALUCTL_SLL;
          FUNCT_SRL:  bus.alucontrol = ALUCTL_SRL;
          FUNCT_SRA:  bus.alucontrol = ALUCTL_SRA;
          default:    bus.illegal    = !hilo_cls;
        endcase
      end
      default: bus.alucontrol = ALUCTL_ADD;
    endcase
    bus.muldiv_sel = rtype & ((bus.funct == FUNCT_MFHI) | (bus.funct == FUNCT_MFLO));
    bus.stall      = bus.valid & bus.busy & hilo_cls & rtype;
    start          = bus.valid & rtype & md_cls & !bus.busy;
    mthi_we        = bus.valid & rtype & (bus.funct == FUNCT_MTHI) & !bus.busy;
    mtlo_we        = bus.valid & rtype & (bus.funct == FUNCT_MTLO) & !bus.busy;
    bus.hilo_rd    = (bus.funct == FUNCT_MFHI) ? hi : lo;
  end
  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_div    (bus.funct[1]),
    .op_signed (!bus.funct[0]),
    .srca      (bus.srca),
    .srcb      (bus.srcb),
    .mthi_we   (mthi_we),
    .mtlo_we   (mtlo_we),
    .hi        (hi),
    .lo        (lo),
    .busy      (bus.busy),
    .divzero   (bus.divzero)
  );
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// tb_alu_ctrl_muldiv: directed decode and mul/div vectors for alu_ctrl_muldiv
module tb_alu_ctrl_muldiv;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  alu_ctrl_muldiv_if #(.WIDTH(32)) bus ();
  alu_ctrl_muldiv #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic dec(input logic [1:0] op, input logic [5:0] f, input logic [3:0] ctl, input logic ill);
    bus.valid = 1'b0;
    bus.aluop = op;
    bus.funct = f;
    #1;
    chk($sformatf("dec_%b_%b_ctl", op, f), bus.alucontrol, ctl);
    chk($sformatf("dec_%b_%b_ill", op, f), bus.illegal, ill);
  endtask
  task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    bus.valid = 1'b0;
    bus.aluop = 2'b10;
    bus.funct = FUNCT_MFHI;
    #1;
    chk({tag, "_hi"}, bus.hilo_rd, hi);
    chk({tag, "_sel"}, bus.muldiv_sel, 1'b1);
    bus.funct = FUNCT_MFLO;
    #1;
    chk({tag, "_lo"}, bus.hilo_rd, lo);
  endtask
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int n);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.aluop = 2'b10;
    bus.funct = f;
    bus.srca  = a;
    bus.srcb  = b;
    @(negedge clk);
    bus.valid = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    reset     = 1'b1;
    bus.valid = 1'b0;
    bus.aluop = 2'b00;
    bus.funct = 6'h00;
    bus.srca  = '0;
    bus.srcb  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_dz", bus.divzero, 1'b0);
    read_hilo("rst", 32'h0, 32'h0);
    dec(2'b00, 6'b101010, 4'b0010, 1'b0);
    dec(2'b01, 6'b100000, 4'b0110, 1'b0);
    dec(2'b11, 6'b100000, 4'b0111, 1'b0);
    dec(2'b10, 6'b100000, 4'b0010, 1'b0);
    dec(2'b10, 6'b100001, 4'b0010, 1'b0);
    dec(2'b10, 6'b100010, 4'b0110, 1'b0);
    dec(2'b10, 6'b100011, 4'b0110, 1'b0);
    dec(2'b10, 6'b100100, 4'b0000, 1'b0);
    dec(2'b10, 6'b100101, 4'b0001, 1'b0);
    dec(2'b10, 6'b100110, 4'b0011, 1'b0);
    dec(2'b10, 6'b100111, 4'b0100, 1'b0);
    dec(2'b10, 6'b101010, 4'b0111, 1'b0);
    dec(2'b10, 6'b101011, 4'b1111, 1'b0);
    dec(2'b10, 6'b000000, 4'b1000, 1'b0);
    dec(2'b10, 6'b000010, 4'b1001, 1'b0);
    dec(2'b10, 6'b000011, 4'b1010, 1'b0);
    dec(2'b10, 6'b011000, 4'b0010, 1'b0);
    dec(2'b10, 6'b011001, 4'b0010, 1'b0);
    dec(2'b10, 6'b011010, 4'b0010, 1'b0);
    dec(2'b10, 6'b011011, 4'b0010, 1'b0);
    dec(2'b10, 6'b010000, 4'b0010, 1'b0);
    dec(2'b10, 6'b010001, 4'b0010, 1'b0);
    dec(2'b10, 6'b010010, 4'b0010, 1'b0);
    dec(2'b10, 6'b010011, 4'b0010, 1'b0);
    dec(2'b10, 6'b111111, 4'b0010, 1'b1);
    dec(2'b10, 6'b000001, 4'b0010, 1'b1);
    bus.aluop = 2'b00;
    bus.funct = 6'b010000;
    #1;
    chk("sel_aluop00", bus.muldiv_sel, 1'b0);
    run_md(FUNCT_MULT, 32'd7, 32'hFFFFFFFD, cyc);
    chk("mult_busy_cyc", cyc, 33);
    chk("mult_dz", bus.divzero, 1'b0);
    read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md(FUNCT_MULTU, 32'd7, 32'hFFFFFFFD, cyc);
    chk("multu_busy_cyc", cyc, 33);
    read_hilo("multu", 32'h00000006, 32'hFFFFFFEB);
    run_md(FUNCT_DIVU, 32'd100, 32'd7, cyc);
    read_hilo("divu", 32'd2, 32'd14);
    run_md(FUNCT_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    chk("div_busy_cyc", cyc, 33);
    read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.aluop = 2'b10;
    bus.funct = FUNCT_MULT;
    bus.srca  = 32'd7;
    bus.srcb  = 32'd3;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy_pre", bus.busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_dz", bus.divzero, 1'b0);
    read_hilo("abort", 32'h0, 32'h0);
    @(negedge clk);
    chk("abort_dz_next", bus.divzero, 1'b0);
    run_md(FUNCT_DIV, 32'd5, 32'd0, cyc);
    chk("dz_pulse", bus.divzero, 1'b1);
    read_hilo("dz", 32'd5, 32'hFFFFFFFF);
    @(negedge clk);
    chk("dz_pulse_end", bus.divzero, 1'b0);
    run_md(FUNCT_DIVU, 32'd9, 32'd0, cyc);
    chk("dzu_pulse", bus.divzero, 1'b1);
    read_hilo("dzu", 32'd9, 32'hFFFFFFFF);
    run_md(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    chk("minneg_dz", bus.divzero, 1'b0);
    read_hilo("minneg", 32'h0, 32'h80000000);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.aluop = 2'b10;
    bus.funct = FUNCT_MTHI;
    bus.srca  = 32'h12345678;
    @(negedge clk);
    bus.funct = FUNCT_MTLO;
    bus.srca  = 32'h9ABCDEF0;
    @(negedge clk);
    read_hilo("mthilo", 32'h12345678, 32'h9ABCDEF0);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.aluop = 2'b10;
    bus.funct = FUNCT_MULT;
    bus.srca  = 32'd3;
    bus.srcb  = 32'd5;
    @(negedge clk);
    bus.funct = FUNCT_ADD;
    #1;
    chk("add_busy", bus.busy, 1'b1);
    chk("add_nostall", bus.stall, 1'b0);
    bus.funct = FUNCT_MTHI;
    #1;
    chk("mthi_stall", bus.stall, 1'b1);
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.valid = 1'b1;
    bus.funct = FUNCT_MFLO;
    #1;
    chk("mflo_stall", bus.stall, 1'b1);
    cyc = 0;
    while (bus.stall && cyc < 100) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("mflo_stall_cyc", cyc, 29);
    chk("mflo_busy", bus.busy, 1'b0);
    chk("mflo_sel", bus.muldiv_sel, 1'b1);
    chk("mflo_rd", bus.hilo_rd, 32'd15);
    bus.valid = 1'b0;
    bus.funct = FUNCT_MFHI;
    #1;
    chk("mfhi_rd", bus.hilo_rd, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
